// File: rtl/joystick_emu_pkg.sv
// Shared Kempston bit positions and serial frame map for the joystick link.
// The reader side uses the same map to unpack the frame.
package joystick_emu_pkg;

    localparam int JOY_R  = 0;
    localparam int JOY_L  = 1;
    localparam int JOY_D  = 2;
    localparam int JOY_U  = 3;
    localparam int JOY_F1 = 4;
    localparam int JOY_F2 = 5;

    localparam int FRAME_W = 16;
    localparam int PORT2_OFS = 8;

    typedef enum logic {
        ST_LOAD,
        ST_SHIFT
    } emu_state_t;

    // Frame bit k is the value the reader latches into Q[k]; port 2 sits at bit 8 upward.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [7:0] p1, input logic [7:0] p2);
        logic [FRAME_W-1:0] f;
        f = '0;
        f[0] = p1[JOY_U];
        f[1] = p1[JOY_D];
        f[2] = p1[JOY_L];
        f[3] = p1[JOY_R];
        f[4] = p1[JOY_F1];
        f[5] = p1[JOY_F2];
        f[PORT2_OFS+0] = p2[JOY_U];
        f[PORT2_OFS+1] = p2[JOY_D];
        f[PORT2_OFS+2] = p2[JOY_L];
        f[PORT2_OFS+3] = p2[JOY_R];
        f[PORT2_OFS+4] = p2[JOY_F1];
        f[PORT2_OFS+5] = p2[JOY_F2];
        return f;
    endfunction

endpackage

// File: rtl/joystick_emu_if.sv
// Three-wire serial joystick link: the reader (master) drives joyCk/joyLd,
// the pad emulator (slave) returns joyD.
interface joystick_emu_if;
    logic joyCk;
    logic joyLd;
    logic joyD;

    modport master (output joyCk, output joyLd, input joyD);
    modport slave  (input joyCk, input joyLd, output joyD);
endinterface

// File: rtl/joystick_emu_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input, with a rising-edge strobe
// taken from the synchronised level.
module sync_edge #(
    parameter int   SYNC    = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [SYNC-1:0] sync_q;
    logic            prev_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC-2:0], din};
            prev_q <= sync_q[SYNC-1];
        end
    end

    assign level = sync_q[SYNC-1];
    assign rise  = sync_q[SYNC-1] & ~prev_q;

endmodule

// File: rtl/joystick_emu.sv
// 74HC165-style parallel-in/serial-out emulator: captures two Kempston pads
// and shifts them out on joyD under the reader's joyLd/joyCk.
module joystick_emu
    import joystick_emu_pkg::*;
#(
    parameter int SYNC  = 2,
    parameter int NBITS = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [7:0]        pad1,
    input  logic [7:0]        pad2,
    joystick_emu_if.slave     link,
    output logic              frameDone,
    output logic [4:0]        bitCount
);

    localparam logic [4:0] CNT_MAX  = 5'(NBITS);
    localparam logic [4:0] CNT_LAST = 5'(NBITS - 1);

    logic               ck_level, ck_rise;
    logic               ld_level, ld_rise;
    logic [FRAME_W-1:0] shreg;
    emu_state_t         state;

    sync_edge #(.SYNC(SYNC), .RST_VAL(1'b0)) u_ck_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (link.joyCk),
        .level   (ck_level),
        .rise    (ck_rise)
    );

    sync_edge #(.SYNC(SYNC), .RST_VAL(1'b1)) u_ld_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (link.joyLd),
        .level   (ld_level),
        .rise    (ld_rise)
    );

    // Pins are active-low, so the register holds the inverted frame, MSB out first.
    assign link.joyD = shreg[FRAME_W-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_SHIFT;
            shreg     <= '1;
            bitCount  <= '0;
            frameDone <= 1'b0;
        end else begin
            frameDone <= 1'b0;
            case (state)
                ST_LOAD: begin
                    shreg    <= ~build_frame(pad1, pad2);
                    bitCount <= '0;
                    if (ld_rise) state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    // A load seen in the same clock as a clock edge takes priority.
                    if (!ld_level) begin
                        state    <= ST_LOAD;
                        shreg    <= ~build_frame(pad1, pad2);
                        bitCount <= '0;
                    end else if (ck_rise && ck_level) begin
                        shreg <= {shreg[FRAME_W-2:0], 1'b1};
                        if (bitCount != CNT_MAX) begin
                            bitCount  <= bitCount + 5'd1;
                            frameDone <= (bitCount == CNT_LAST);
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_joystick_emu.sv
// Randomised bench for joystick_emu: stimulus pushes expected pin/count state into a
// scoreboard queue, a negedge monitor pops and compares once the sync latency has elapsed.
module tb_joystick_emu;

    localparam int SYNC = 2;
    localparam int HALF = 6;
    localparam int DUE  = SYNC + 2;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] pad1 = 8'h00;
    logic [7:0] pad2 = 8'h00;
    logic       frameDone;
    logic [4:0] bitCount;

    joystick_emu_if link();

    joystick_emu #(.SYNC(SYNC), .NBITS(16)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .pad1      (pad1),
        .pad2      (pad2),
        .link      (link),
        .frameDone (frameDone),
        .bitCount  (bitCount)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic       jd;
        logic [4:0] cnt;
        int         done;
        int         tag;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   done_seen = 0;

    // Reference model: frame contents and number of shifts since the last load.
    logic [15:0] m_frame = 16'h0000;
    int          m_shifts = 0;
    int          m_done = 0;
    bit          m_ld_low = 0;
    int          tag_n = 0;

    function automatic logic [15:0] ref_frame(input logic [7:0] a, input logic [7:0] b);
        int          order[6];
        logic [15:0] f;
        order[0] = 3; order[1] = 2; order[2] = 1;   // U, D, L
        order[3] = 0; order[4] = 4; order[5] = 5;   // R, F1, F2
        f = 16'h0000;
        for (int k = 0; k < 6; k++) begin
            f[k]     = a[order[k]];
            f[8 + k] = b[order[k]];
        end
        return f;
    endfunction

    task automatic push_exp();
        exp_t x;
        x.due  = cyc + DUE;
        x.jd   = (m_shifts < 16) ? ~m_frame[15 - m_shifts] : 1'b1;
        x.cnt  = (m_shifts > 16) ? 5'd16 : 5'(m_shifts);
        x.done = m_done;
        x.tag  = tag_n;
        tag_n++;
        sbq.push_back(x);
    endtask

    task automatic check_now(input string name, input logic [4:0] got, input logic [4:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    always @(negedge clock) begin
        if (frameDone === 1'b1) done_seen++;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            checks += 3;
            if (link.joyD !== e.jd) begin
                errors++;
                $display("FAIL joyD#%0d: got %b expected %b", e.tag, link.joyD, e.jd);
            end
            if (bitCount !== e.cnt) begin
                errors++;
                $display("FAIL bitCount#%0d: got %0d expected %0d", e.tag, bitCount, e.cnt);
            end
            if (done_seen != e.done) begin
                errors++;
                $display("FAIL frameDone_count#%0d: got %0d expected %0d", e.tag, done_seen, e.done);
            end
        end
    end

    task automatic ck_pulse();
        @(posedge clock); #1;
        link.joyCk = 1'b1;
        if (!m_ld_low) begin
            m_shifts++;
            if (m_shifts == 16) m_done++;
        end
        push_exp();
        repeat (HALF) @(posedge clock);
        #1 link.joyCk = 1'b0;
        repeat (HALF) @(posedge clock);
    endtask

    task automatic load(input logic [7:0] p1, input logic [7:0] p2, input int toggles, input bit change);
        pad1 = p1;
        pad2 = p2;
        @(posedge clock); #1;
        link.joyLd = 1'b0;
        m_ld_low = 1;
        m_frame  = ref_frame(p1, p2);
        m_shifts = 0;
        push_exp();
        repeat (HALF) @(posedge clock);
        for (int i = 0; i < toggles; i++) ck_pulse();
        if (change) begin
            #1;
            pad1 = 8'($urandom);
            pad2 = 8'($urandom);
            m_frame = ref_frame(pad1, pad2);
            push_exp();
            repeat (HALF) @(posedge clock);
        end
        #1 link.joyLd = 1'b1;
        m_ld_low = 0;
        push_exp();
        repeat (HALF) @(posedge clock);
    endtask

    task automatic shifts(input int n, input int change_at);
        for (int i = 1; i <= n; i++) begin
            ck_pulse();
            if (i == change_at) begin
                pad1 = 8'($urandom);
                pad2 = 8'($urandom);
            end
        end
    endtask

    task automatic drain();
        int budget;
        budget = 200;
        while (sbq.size() > 0 && budget > 0) begin
            @(posedge clock);
            budget--;
        end
        if (sbq.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r1, r2;
        link.joyCk = 1'b0;
        link.joyLd = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_now("reset_joyD", {4'd0, link.joyD}, 5'd1);
        check_now("reset_bitCount", bitCount, 5'd0);
        check_now("reset_frameDone", {4'd0, frameDone}, 5'd0);
        @(posedge clock); #1 reset_n = 1'b1;
        repeat (3) @(posedge clock);

        // Single buttons on each port, one full frame.
        load(8'h01, 8'h10, 0, 0);
        shifts(16, 0);

        // Pad change after shift 3 must not disturb the frame in flight.
        load(8'h08, 8'h00, 0, 0);
        pad1 = 8'h08;
        for (int i = 1; i <= 16; i++) begin
            ck_pulse();
            if (i == 3) pad1 = 8'h04;
        end
        load(8'h04, 8'h00, 0, 0);
        shifts(16, 0);

        // Clock edges while load is held are ignored; transparent reload while low.
        load(8'h3F, 8'h2A, 5, 0);
        shifts(4, 0);
        load(8'h15, 8'h3F, 2, 1);
        shifts(16, 0);

        // Randomised frames, including short, full and over-long shift runs.
        for (int f = 0; f < 10; f++) begin
            r1 = 8'($urandom);
            r2 = 8'($urandom);
            load(r1, r2, int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
            shifts(int'($urandom_range(8, 20)), int'($urandom_range(1, 6)));
        end

        // Over-shift: 20 clocks, last four shift in idle 1s.
        load(8'h3F, 8'h3F, 0, 0);
        shifts(20, 0);

        // Asynchronous reset mid-frame.
        load(8'h2D, 8'h1B, 0, 0);
        shifts(7, 0);
        drain();
        @(posedge clock); #1 reset_n = 1'b0;
        #1;
        check_now("midreset_joyD", {4'd0, link.joyD}, 5'd1);
        check_now("midreset_bitCount", bitCount, 5'd0);
        check_now("midreset_frameDone", {4'd0, frameDone}, 5'd0);
        m_frame = 16'h0000;
        m_shifts = 0;
        m_ld_low = 0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clock);
        shifts(18, 0);
        load(8'h22, 8'h11, 0, 0);
        shifts(16, 0);

        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
